// File: rtl/dot_accumulator_if.sv
// Handshake bundle between the vector multiplier, the dot accumulator and its consumer.
// The master drives partial products and out_ready; the slave (accumulator) returns results.
interface dot_accumulator_if #(
  parameter int W_X   = 8,
  parameter int W_OUT = 8
);
  logic                    in_valid;
  logic signed [W_X-1:0]   in_data;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [W_OUT-1:0] out_data;
  logic                    out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/dot_accumulator.sv
// Sums N_CHUNK signed partial dot products into one full result, saturates it to W_OUT
// and holds it on a valid/ready output, stalling the multiplier while the result waits.
module dot_accumulator #(
  parameter int W_X     = 8,
  parameter int N_CHUNK = 4,
  parameter int W_OUT   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic             busy,
  dot_accumulator_if.slave bus
);
  localparam int W_ACC = W_X + $clog2(N_CHUNK) + 1;
  localparam int CW    = $clog2(N_CHUNK + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_CHUNK - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                  state;
  logic signed [W_ACC-1:0] acc;
  logic [CW-1:0]           cnt;
  logic                    out_valid_q;
  logic signed [W_OUT-1:0] out_data_q;
  logic                    out_sat_q;

  logic                    accept;
  logic signed [W_ACC-1:0] in_ext;
  logic signed [W_ACC-1:0] sum;
  logic signed [W_OUT-1:0] sat_data;
  logic                    sat_flag;

  assign bus.in_ready  = !rst && !clear && (state != HOLD);
  assign accept        = bus.in_valid && bus.in_ready;
  assign in_ext        = W_ACC'(bus.in_data);
  assign sum           = acc + in_ext;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign busy          = (state == ACCUM) || (state == HOLD);

  // The accumulator is sized so that it can never wrap; only the final narrowing can clip.
  generate
    if (W_OUT >= W_ACC) begin : g_wide
      assign sat_data = W_OUT'(sum);
      assign sat_flag = 1'b0;
    end else begin : g_narrow
      localparam logic signed [W_ACC-1:0] SAT_MAX = W_ACC'((2 ** (W_OUT - 1)) - 1);
      localparam logic signed [W_ACC-1:0] SAT_MIN = ~SAT_MAX;
      logic over_hi;
      logic over_lo;
      assign over_hi  = sum > SAT_MAX;
      assign over_lo  = sum < SAT_MIN;
      assign sat_data = over_hi ? SAT_MAX[W_OUT-1:0] :
                        over_lo ? SAT_MIN[W_OUT-1:0] : sum[W_OUT-1:0];
      assign sat_flag = over_hi || over_lo;
    end
  endgenerate

  // acc is zero in IDLE, so the first beat and later beats share the same add path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (clear) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
          end else if (accept) begin
            if (cnt == LAST_CNT) begin
              state       <= HOLD;
              out_valid_q <= 1'b1;
              out_data_q  <= sat_data;
              out_sat_q   <= sat_flag;
              acc         <= '0;
              cnt         <= '0;
            end else begin
              state <= ACCUM;
              acc   <= sum;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dot_accumulator.sv
// Randomized and directed checks of dot_accumulator against an integer-arithmetic model;
// a second instance with N_CHUNK=1 checks the back-to-back result cadence.
module tb_dot_accumulator;
  localparam int W_X     = 8;
  localparam int N_CHUNK = 4;
  localparam int W_OUT   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clear, busy;
  logic rst1, clear1, busy1;

  dot_accumulator_if #(.W_X(W_X), .W_OUT(W_OUT)) bus ();
  dot_accumulator_if #(.W_X(W_X), .W_OUT(W_OUT)) bus1 ();

  dot_accumulator #(.W_X(W_X), .N_CHUNK(N_CHUNK), .W_OUT(W_OUT)) dut (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy), .bus(bus.slave)
  );

  dot_accumulator #(.W_X(W_X), .N_CHUNK(1), .W_OUT(W_OUT)) dut1 (
    .clk(clk), .rst(rst1), .clear(clear1), .busy(busy1), .bus(bus1.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Model: plain integer running sum, beat count and the result waiting for the consumer.
  int m_sum, m_cnt, m_res;
  bit m_hold, m_sat;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_res = 0; m_sat = 0; m_hold = 0;
  endtask

  task automatic model_finish();
    int hi, lo;
    hi = (2 ** (W_OUT - 1)) - 1;
    lo = -(2 ** (W_OUT - 1));
    m_sat = (m_sum > hi) || (m_sum < lo);
    m_res = (m_sum > hi) ? hi : (m_sum < lo) ? lo : m_sum;
    m_hold = 1;
    m_sum = 0;
    m_cnt = 0;
  endtask

  task automatic applyStimulus(input bit r, input bit c, input bit v, input int d, input bit ordy);
    @(negedge clk);
    rst = r; clear = c;
    bus.in_valid = v; bus.in_data = W_X'(d); bus.out_ready = ordy;
    #1;
    checkOutput("in_ready", int'(bus.in_ready), int'(!r && !c && !m_hold));
    checkOutput("out_valid", int'(bus.out_valid), int'(m_hold));
    checkOutput("out_data", int'(bus.out_data), m_res);
    checkOutput("out_sat", int'(bus.out_sat), int'(m_sat));
    checkOutput("busy", int'(busy), int'(m_hold || (m_cnt > 0)));
    @(posedge clk);
    if (r) model_reset();
    else if (m_hold) begin
      if (ordy) m_hold = 0;
    end else if (c) begin
      m_sum = 0; m_cnt = 0;
    end else if (v) begin
      m_sum += d;
      m_cnt++;
      if (m_cnt == N_CHUNK) model_finish();
    end
  endtask

  task automatic send_beats(input int vals[]);
    foreach (vals[i]) applyStimulus(0, 0, 1, vals[i], 1);
  endtask

  task automatic check_result(input string tag, input int data, input int sat);
    #1;
    checkOutput({tag, "_data"}, int'(bus.out_data), data);
    checkOutput({tag, "_sat"}, int'(bus.out_sat), sat);
  endtask

  initial begin
    rst = 1; clear = 0; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    rst1 = 1; clear1 = 0; bus1.in_valid = 0; bus1.in_data = '0; bus1.out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state is checked by the first idle step.
    applyStimulus(0, 0, 0, 0, 1);

    send_beats('{10, 20, -5, 7});
    applyStimulus(0, 0, 0, 0, 1);
    check_result("sum32", 32, 0);

    send_beats('{100, 100, 100, 100});
    applyStimulus(0, 0, 0, 0, 1);
    check_result("sat_hi", 127, 1);
    send_beats('{-128, -128, -128, -128});
    applyStimulus(0, 0, 0, 0, 1);
    check_result("sat_lo", -128, 1);

    // Backpressure: result held while in_valid keeps offering beats.
    send_beats('{1, 2, 3, 4});
    repeat (5) applyStimulus(0, 0, 1, 50, 0);
    applyStimulus(0, 0, 1, 50, 1);
    applyStimulus(0, 0, 0, 0, 1);
    check_result("hold", 10, 0);

    send_beats('{3, 4});
    applyStimulus(0, 1, 1, 9, 1);
    send_beats('{1, 1, 1, 1});
    applyStimulus(0, 0, 0, 0, 1);
    check_result("clear", 4, 0);

    send_beats('{5, 5, 5});
    applyStimulus(1, 0, 1, 5, 1);
    applyStimulus(0, 0, 0, 0, 1);
    check_result("rst_mid", 0, 0);
    send_beats('{2, 2, 2, 2});
    applyStimulus(0, 0, 0, 0, 1);
    check_result("after_rst", 8, 0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
                    int'($urandom_range(255)) - 128, ($urandom % 3) != 0);
    end
    applyStimulus(0, 0, 0, 0, 1);

    // Single-beat results: accept, present, accept, present ...
    @(negedge clk);
    rst1 = 0; bus1.in_valid = 1; bus1.in_data = -8'sd3; bus1.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput("n1_out_valid", int'(bus1.out_valid), int'((i % 2) == 0));
      checkOutput("n1_in_ready", int'(bus1.in_ready), int'((i % 2) != 0));
      checkOutput("n1_out_data", int'(bus1.out_data), -3);
      checkOutput("n1_out_sat", int'(bus1.out_sat), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
